spi_bridge: RTL and testbench

- SPI slave front end for the PWM generator register path; sits directly upstream of the instruction decoder.
- Oversamples the external SPI pins (sclk, cs_n, mosi) in the peripheral clock domain and deserialises MOSI into bytes, pulsing byte_sync once per completed byte.
- Serialises the decoder's data_out byte onto MISO.
- SPI mode 0 only: CPOL=0, CPHA=0, MSB first, 8-bit frames, any number of bytes per cs_n assertion.

---
 rtl/spi_bridge_if.sv | 21 ++
 rtl/spi_bridge.sv | 102 ++++++++++
 tb/tb_spi_bridge.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_bridge_if.sv
// SPI pins plus the decoder-side byte path of the SPI slave bridge.
// The bridge uses the slave modport; the SPI host and decoder use the master modport.
interface spi_bridge_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport slave (
    input  sclk, cs_n, mosi, data_out,
    output miso, byte_sync, data_in
  );

  modport master (
    output sclk, cs_n, mosi, data_out,
    input  miso, byte_sync, data_in
  );
endinterface

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end: oversamples the SPI pins in the clk domain,
// deserialises MOSI into bytes for the decoder and serialises data_out onto MISO.
module spi_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_bridge_if.slave bus
);

  localparam int LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q,   cs_hist_d;
  logic [2:0]             bit_cnt_q,   bit_cnt_d;
  logic [7:0]             rx_shift_q,  rx_shift_d;
  logic [7:0]             tx_shift_q,  tx_shift_d;
  logic [7:0]             data_in_q,   data_in_d;
  logic                   byte_sync_q, byte_sync_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall;

  assign sclk_s    = sclk_sync_q[LAST];
  assign cs_s      = cs_sync_q[LAST];
  assign mosi_s    = mosi_sync_q[LAST];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    data_in_d   = data_in_q;
    byte_sync_d = 1'b0;

    // Deselect wins over any sclk edge detected in the same cycle.
    if (cs_s) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
      tx_shift_d = 8'h00;
    end else if (cs_fall) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
      tx_shift_d = bus.data_out;
    end else begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_in_d   = {rx_shift_q[6:0], mosi_s};
          byte_sync_d = 1'b1;
        end
      end
      if (sclk_fall) begin
        // Count back at zero means a byte boundary: fetch the decoder's reply.
        if (bit_cnt_q == 3'd0) tx_shift_d = bus.data_out;
        else                   tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      data_in_q   <= 8'h00;
      byte_sync_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      data_in_q   <= data_in_d;
      byte_sync_q <= byte_sync_d;
    end
  end

  assign bus.miso      = ~cs_s & tx_shift_q[7];
  assign bus.byte_sync = byte_sync_q;
  assign bus.data_in   = data_in_q;

endmodule

// File: tb/tb_spi_bridge.sv
// Bench for spi_bridge: an SPI master and decoder model drive the bridge while a
// monitor pops expected bytes and their arrival cycle from a scoreboard queue.
module tb_spi_bridge;

  localparam int SYNC = 2;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] last_exp;

  spi_bridge_if ifc();

  spi_bridge #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every byte_sync cycle must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ifc.byte_sync === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte_sync", {24'h0, ifc.data_in}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("byte_data", {24'h0, ifc.data_in}, {24'h0, e.data});
          check("byte_latency", cyc, e.cyc);
        end
      end
    end
  end

  // Decoder model: one clk after byte_sync it presents its next reply on data_out.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ifc.byte_sync === 1'b1 && rsp_q.size() > 0) begin
        @(posedge clk);
        #1 ifc.data_out = rsp_q.pop_front();
      end
    end
  end

  task automatic spi_byte(input logic [7:0] tx, input int ph, input logic [7:0] exp_miso,
                          input int nbits);
    exp_t e;
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      ifc.mosi = tx[7-i];
      repeat (ph) @(negedge clk);
      r[7-i] = ifc.miso;
      ifc.sclk = 1'b1;
      if (i == 7) begin
        e.data = tx;
        e.cyc  = cyc + 1 + SYNC;
        exp_q.push_back(e);
        last_exp = tx;
      end
      repeat (ph) @(negedge clk);
      ifc.sclk = 1'b0;
    end
    if (nbits == 8) check("miso_byte", {24'h0, r}, {24'h0, exp_miso});
  endtask

  // Sends tx_q in one cs_n frame; the last byte is cut to abort_bits when nonzero.
  task automatic frame(input logic [7:0] init, input int abort_bits, input int ph);
    logic [7:0] rsp_copy[$];
    logic [7:0] exp_miso;
    int nb;
    rsp_copy = rsp_q;
    ifc.data_out = init;
    ifc.cs_n = 1'b0;
    repeat (ph + 2) @(negedge clk);
    for (int k = 0; k < tx_q.size(); k++) begin
      nb = (abort_bits != 0 && k == tx_q.size() - 1) ? abort_bits : 8;
      exp_miso = (k == 0) ? init : ((k - 1 < rsp_copy.size()) ? rsp_copy[k-1] : init);
      spi_byte(tx_q[k], ph, exp_miso, nb);
    end
    repeat (ph) @(negedge clk);
    ifc.cs_n = 1'b1;
    repeat (ph + 6) @(negedge clk);
    tx_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    int nbytes;
    int abort_bits;
    logic [7:0] init;
    logic [7:0] prev;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    ifc.sclk = 1'b0;
    ifc.cs_n = 1'b1;
    ifc.mosi = 1'b0;
    ifc.data_out = 8'h00;
    last_exp = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_miso", {31'h0, ifc.miso}, 32'h0);
    check("reset_byte_sync", {31'h0, ifc.byte_sync}, 32'h0);
    check("reset_data_in", {24'h0, ifc.data_in}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write transaction
    tx_q = '{8'h85, 8'hAB};
    frame(8'h00, 0, 5);
    check("write_data_in", {24'h0, ifc.data_in}, 32'hAB);

    // Readback: reply 0x3C appears in the byte after the second one
    tx_q  = '{8'h20, 8'h41, 8'h00};
    rsp_q = '{8'h00, 8'h3C};
    frame(8'h00, 0, 4);

    // Abort after 5 bits of 0xFF, then a clean frame
    tx_q = '{8'hFF};
    frame(8'h00, 5, 4);
    check("abort_data_in_kept", {24'h0, ifc.data_in}, 32'h00);
    tx_q = '{8'h12};
    frame(8'h00, 0, 4);
    check("after_abort_data_in", {24'h0, ifc.data_in}, 32'h12);

    // Deselected noise
    ifc.mosi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ifc.sclk = ~ifc.sclk;
      repeat (4) begin
        @(negedge clk);
        check("noise_miso", {31'h0, ifc.miso}, 32'h0);
      end
    end
    ifc.sclk = 1'b0;
    repeat (6) @(negedge clk);
    check("noise_data_in", {24'h0, ifc.data_in}, 32'h12);

    // Reset mid-byte
    ifc.data_out = 8'hC3;
    ifc.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_byte(8'hF0, 4, 8'h00, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_miso", {31'h0, ifc.miso}, 32'h0);
    check("midrst_byte_sync", {31'h0, ifc.byte_sync}, 32'h0);
    check("midrst_data_in", {24'h0, ifc.data_in}, 32'h0);
    rst_n = 1'b1;
    last_exp = 8'h00;
    repeat (4) @(negedge clk);
    ifc.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    tx_q = '{8'hA5};
    frame(8'h5A, 0, 4);
    check("midrst_new_byte", {24'h0, ifc.data_in}, 32'hA5);

    // Back-to-back at the minimum phase
    tx_q  = '{8'h01, 8'h02, 8'h04, 8'h80};
    rsp_q = '{8'h11, 8'h22, 8'h33};
    frame(8'h99, 0, 4);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      nbytes = $urandom_range(1, 4);
      abort_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      init = 8'($urandom);
      for (int k = 0; k < nbytes; k++) begin
        tx_q.push_back(8'($urandom));
        rsp_q.push_back(8'($urandom));
      end
      prev = last_exp;
      frame(init, abort_bits, $urandom_range(4, 7));
      if (abort_bits != 0 && nbytes == 1)
        check("rand_abort_data_in", {24'h0, ifc.data_in}, {24'h0, prev});
      else
        check("rand_data_in", {24'h0, ifc.data_in}, {24'h0, last_exp});
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
